fetch_decode_buffer: RTL and testbench

//  Elastic IF/ID boundary between the fetch stage and decode. Captures each fetched instruction

---
 rtl/processor_pkg.sv | 13 +
 rtl/fd_entry_ram.sv | 39 +++
 rtl/fetch_decode_buffer.sv | 119 +++++++++++
 tb/tb_fetch_decode_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared types for the IF/ID boundary: instruction width, NOP encoding and the
// buffered entry record (instruction plus its PC+8).
package processor_pkg;

  localparam int INSTR_W = 22;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus_8;
  } fd_entry_t;

endpackage

// File: rtl/fd_entry_ram.sv
// DEPTH x fd_entry_t register storage for the fetch/decode buffer.
// One write port, combinational read port, asynchronous clear on active-low rst.
module fd_entry_ram
  import processor_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fd_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fd_entry_t     rdata
);

  fd_entry_t entries [DEPTH];

  // One register per entry keeps each slot's reset and write enable independent.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      fd_entry_t entry_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_q <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          entry_q <= wdata;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  assign rdata = entries[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID FIFO between fetch and decode; flush squashes all held entries.
// Define FD_BUFFER_STATS_EN to add the stall_cycles / flush_count statistics outputs.
module fetch_decode_buffer
  import processor_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [WIDTH-1:0] f_instr,
  input  logic [WIDTH-1:0] f_pc_plus_8,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_instr,
  output logic [WIDTH-1:0] d_pc_plus_8,
  output logic [CW-1:0]    occupancy
`ifdef FD_BUFFER_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [7:0]       flush_count
`endif
);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          push, pop;
  fd_entry_t     wr_entry, head_entry;

  // Handshakes depend on state only, so there is no combinational path fetch <-> decode.
  assign f_ready = (count_q != CW'(DEPTH));
  assign d_valid = (count_q != '0);
  assign push    = f_valid & f_ready;
  assign pop     = d_valid & d_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // A pop this cycle still reaches decode; a push this cycle is dropped.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_entry.instr     = f_instr;
  assign wr_entry.pc_plus_8 = f_pc_plus_8;

  fd_entry_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  assign d_instr     = d_valid ? head_entry.instr     : NOP_INSTR;
  assign d_pc_plus_8 = d_valid ? head_entry.pc_plus_8 : '0;
  assign occupancy   = count_q;

`ifdef FD_BUFFER_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [7:0]  flushes_q, flushes_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_d   = stall_q;
    flushes_d = flushes_q;
    if (f_valid && !f_ready && (stall_q != '1)) stall_d   = stall_q + 16'd1;
    if (flush && (flushes_q != '1))             flushes_d = flushes_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      flushes_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flushes_q <= flushes_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed, table-driven bench for fetch_decode_buffer (DEPTH=2, WIDTH=22),
// plus hand-written sequences for async reset and the optional statistics counters.
module tb_fetch_decode_buffer;

  localparam int W = 22;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         f_valid;
  logic         f_ready;
  logic [W-1:0] f_instr;
  logic [W-1:0] f_pc_plus_8;
  logic         d_valid;
  logic         d_ready;
  logic [W-1:0] d_instr;
  logic [W-1:0] d_pc_plus_8;
  logic [1:0]   occupancy;
`ifdef FD_BUFFER_STATS_EN
  logic [15:0]  stall_cycles;
  logic [7:0]   flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode_buffer #(.WIDTH(W), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .f_valid     (f_valid),
    .f_ready     (f_ready),
    .f_instr     (f_instr),
    .f_pc_plus_8 (f_pc_plus_8),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_instr     (d_instr),
    .d_pc_plus_8 (d_pc_plus_8),
    .occupancy   (occupancy)
`ifdef FD_BUFFER_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  typedef struct {
    logic         fl;
    logic         fv;
    logic [W-1:0] instr;
    logic [W-1:0] pc;
    logic         dr;
    logic         exp_dv;
    logic [W-1:0] exp_di;
    logic [W-1:0] exp_dp;
    logic [1:0]   exp_occ;
    logic         exp_fr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic fv, input logic [W-1:0] instr,
                     input logic [W-1:0] pc, input logic dr, input logic dv,
                     input logic [W-1:0] di, input logic [W-1:0] dp,
                     input logic [1:0] occ, input logic fr);
    vec_t v;
    v.fl = fl; v.fv = fv; v.instr = instr; v.pc = pc; v.dr = dr;
    v.exp_dv = dv; v.exp_di = di; v.exp_dp = dp; v.exp_occ = occ; v.exp_fr = fr;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic dv, input logic [W-1:0] di,
                               input logic [W-1:0] dp, input logic [1:0] occ, input logic fr);
    check({tag, ".d_valid"},     32'(d_valid),     32'(dv));
    check({tag, ".d_instr"},     32'(d_instr),     32'(di));
    check({tag, ".d_pc_plus_8"}, 32'(d_pc_plus_8), 32'(dp));
    check({tag, ".occupancy"},   32'(occupancy),   32'(occ));
    check({tag, ".f_ready"},     32'(f_ready),     32'(fr));
    check({tag, ".occ_bound"},   32'(occupancy <= 2'd2), 32'd1);
  endtask

  initial begin
    // Reset held with fetch offering and a flush pending: reset wins.
    rst = 1'b0; flush = 1'b1; f_valid = 1'b1; d_ready = 1'b0;
    f_instr = 22'h0ABCDE; f_pc_plus_8 = 22'h000008;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, '0, '0, 2'd0, 1'b1);
    $display("txn reset: d_valid=%0b occ=%0d f_ready=%0b", d_valid, occupancy, f_ready);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; f_valid = 1'b0;

    //   fl   fv   instr        pc           dr    dv    d_instr      d_pc         occ   fr
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b0, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    add(1'b0, 1'b1, 22'h0ABCDE, 22'h000008, 1'b0, 1'b1, 22'h0ABCDE, 22'h000008, 2'd1, 1'b1);
    add(1'b0, 1'b1, 22'h012345, 22'h000010, 1'b0, 1'b1, 22'h0ABCDE, 22'h000008, 2'd2, 1'b0);
    add(1'b0, 1'b1, 22'h3FFFFF, 22'h000018, 1'b0, 1'b1, 22'h0ABCDE, 22'h000008, 2'd2, 1'b0);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b1, 1'b1, 22'h012345, 22'h000010, 2'd1, 1'b1);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b1, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    // Occupancy 1, then simultaneous push+pop for 8 cycles (pointers wrap repeatedly).
    add(1'b0, 1'b1, 22'h000100, 22'h000200, 1'b0, 1'b1, 22'h000100, 22'h000200, 2'd1, 1'b1);
    for (int k = 1; k <= 8; k++)
      add(1'b0, 1'b1, 22'h000100 + W'(k), 22'h000200 + W'(8 * k), 1'b1,
          1'b1, 22'h000100 + W'(k), 22'h000200 + W'(8 * k), 2'd1, 1'b1);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b1, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    // Fill, then flush with fetch offering: the offered instruction never appears.
    add(1'b0, 1'b1, 22'h0000B0, 22'h000300, 1'b0, 1'b1, 22'h0000B0, 22'h000300, 2'd1, 1'b1);
    add(1'b0, 1'b1, 22'h0000B1, 22'h000308, 1'b0, 1'b1, 22'h0000B0, 22'h000300, 2'd2, 1'b0);
    add(1'b1, 1'b1, 22'h03DEAD, 22'h03EEEE, 1'b0, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b0, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    // Flush with a concurrent pop, and flush of an empty buffer with a push offered.
    add(1'b0, 1'b1, 22'h0000C0, 22'h000400, 1'b0, 1'b1, 22'h0000C0, 22'h000400, 2'd1, 1'b1);
    add(1'b1, 1'b1, 22'h0000C1, 22'h000408, 1'b1, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    add(1'b1, 1'b1, 22'h0000C2, 22'h000410, 1'b0, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b0, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);
    // Entry after a flush lands in slot 0 and is presented normally.
    add(1'b0, 1'b1, 22'h0000D0, 22'h000500, 1'b0, 1'b1, 22'h0000D0, 22'h000500, 2'd1, 1'b1);
    add(1'b0, 1'b0, 22'h0,      22'h0,      1'b1, 1'b0, 22'h0,      22'h0,      2'd0, 1'b1);

    foreach (vecs[i]) begin
      flush = vecs[i].fl; f_valid = vecs[i].fv; f_instr = vecs[i].instr;
      f_pc_plus_8 = vecs[i].pc; d_ready = vecs[i].dr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_dv, vecs[i].exp_di,
                    vecs[i].exp_dp, vecs[i].exp_occ, vecs[i].exp_fr);
      $display("txn vec%0d: fl=%0b fv=%0b in=%h dr=%0b -> dv=%0b d_instr=%h d_pc=%h occ=%0d fr=%0b",
               i, vecs[i].fl, vecs[i].fv, vecs[i].instr, vecs[i].dr,
               d_valid, d_instr, d_pc_plus_8, occupancy, f_ready);
    end

    // Asynchronous reset mid-cycle drops the held entry without a clock edge.
    flush = 1'b0; f_valid = 1'b1; d_ready = 1'b0;
    f_instr = 22'h2AAAAA; f_pc_plus_8 = 22'h000600;
    @(posedge clk);
    #1;
    check("async.pre_dv", 32'(d_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_outputs("async", 1'b0, '0, '0, 2'd0, 1'b1);
    $display("txn async_reset: d_valid=%0b occ=%0d", d_valid, occupancy);
    @(negedge clk);
    rst = 1'b1; f_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("after_async", 1'b0, '0, '0, 2'd0, 1'b1);
    $display("txn after_async: d_valid=%0b occ=%0d", d_valid, occupancy);

`ifdef FD_BUFFER_STATS_EN
    check("stats.stall_rst", 32'(stall_cycles), 32'd0);
    check("stats.flush_rst", 32'(flush_count), 32'd0);
    f_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stats.stall_fill", 32'(stall_cycles), 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    check("stats.stall_sat", 32'(stall_cycles), 32'h0000FFFF);
    $display("txn stall_hold: stall_cycles=%h", stall_cycles);
    f_valid = 1'b0; flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b0;
    check("stats.flush_count", 32'(flush_count), 32'd3);
    check("stats.stall_held", 32'(stall_cycles), 32'h0000FFFF);
    $display("txn flushes: flush_count=%0d", flush_count);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
